// File: rtl/sseg_if.sv
// Bundle between a 7-segment reader and whoever watches it.
// The master drives the segment lines; the slave (the decoder) reports what it read.
interface sseg_if;
  logic       enable;
  logic [6:0] display;
  logic [4:0] hexa;
  logic       valid;
  logic       erro;
  logic       apagado;
  logic [7:0] contagem;

  modport master (
    output enable, display,
    input  hexa, valid, erro, apagado, contagem
  );

  modport slave (
    input  enable, display,
    output hexa, valid, erro, apagado, contagem
  );
endinterface

// File: rtl/sseg_decodificador.sv
// Reads an active-low 7-segment pattern, waits until it has been stable for
// STABLE_CYCLES synchronized samples, then decodes it back to its 5-bit code.
module sseg_decodificador #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic   clock,
  input  logic   reset,
  sseg_if.slave  bus
);

  typedef enum logic {IDLE, TRACK} state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  localparam logic [6:0] BLANK  = 7'h7F;

  state_t     state;
  logic [6:0] s1, s2;
  logic [6:0] cand, aceito;
  logic [7:0] cnt;

  logic [6:0] next_cand;
  logic [7:0] next_cnt;
  logic       reach;
  logic [6:0] dec;

  // Result packed as {hexa[4:0], erro, apagado}.
  function automatic logic [6:0] decode(input logic [6:0] p);
    case (p)
      7'h40: return {5'h00, 2'b00};
      7'h79: return {5'h01, 2'b00};
      7'h24: return {5'h02, 2'b00};
      7'h30: return {5'h03, 2'b00};
      7'h19: return {5'h04, 2'b00};
      7'h12: return {5'h05, 2'b00};
      7'h02: return {5'h06, 2'b00};
      7'h78: return {5'h07, 2'b00};
      7'h00: return {5'h08, 2'b00};
      7'h10: return {5'h09, 2'b00};
      7'h08: return {5'h0A, 2'b00};
      7'h03: return {5'h0B, 2'b00};
      7'h46: return {5'h0C, 2'b00};
      7'h21: return {5'h0D, 2'b00};
      7'h06: return {5'h0E, 2'b00};
      7'h0E: return {5'h0F, 2'b00};
      7'h7E: return {5'h10, 2'b00};
      7'h7D: return {5'h11, 2'b00};
      7'h7B: return {5'h12, 2'b00};
      7'h77: return {5'h13, 2'b00};
      7'h6F: return {5'h14, 2'b00};
      7'h5F: return {5'h15, 2'b00};
      7'h7F: return {5'h1F, 2'b01};
      default: return {5'h1E, 2'b10};
    endcase
  endfunction

  // A changed sample reloads the candidate at count 1, so with STABLE_CYCLES=1
  // the reload itself is the moment the count reaches its target.
  always_comb begin
    next_cand = cand;
    next_cnt  = cnt;
    if (s2 != cand) begin
      next_cand = s2;
      next_cnt  = 8'd1;
    end else if (cnt < STABLE) begin
      next_cnt = cnt + 8'd1;
    end
    reach = (next_cnt == STABLE) && ((s2 != cand) || (cnt != STABLE));
    dec   = decode(next_cand);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s1           <= BLANK;
      s2           <= BLANK;
      cand         <= BLANK;
      aceito       <= BLANK;
      cnt          <= 8'd0;
      bus.hexa     <= 5'h1F;
      bus.erro     <= 1'b0;
      bus.apagado  <= 1'b1;
      bus.valid    <= 1'b0;
      bus.contagem <= 8'd0;
    end else begin
      s1        <= bus.display;
      s2        <= s1;
      bus.valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (bus.enable) state <= TRACK;
        end
        TRACK: begin
          if (!bus.enable) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else begin
            cand <= next_cand;
            cnt  <= next_cnt;
            // Returning to the already accepted pattern never re-fires.
            if (reach && (next_cand != aceito)) begin
              aceito       <= next_cand;
              bus.hexa     <= dec[6:2];
              bus.erro     <= dec[1];
              bus.apagado  <= dec[0];
              bus.valid    <= 1'b1;
              bus.contagem <= bus.contagem + 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_decodificador.sv
// Self-checking bench for sseg_decodificador: directed vector sweep, corner
// sequences and random stimulus against a run-length reference model.
module tb_sseg_decodificador;

  localparam int N = 4;

  typedef struct {
    logic [6:0] pattern;
    logic [4:0] hexa;
    logic       erro;
    logic       apagado;
  } vec_t;

  logic   clock;
  logic   reset;
  sseg_if bus ();

  sseg_decodificador #(.STABLE_CYCLES(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  vec_t vecs[25];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   valid_seen = 0;

  // Reference model: acceptance happens when the synchronized pattern has been
  // seen for exactly N consecutive enabled tracking edges and differs from the
  // last accepted one.
  logic [6:0] m_s1, m_s2, m_last, m_acc;
  bit         m_track;
  int         m_run;
  logic [4:0] m_hexa;
  logic       m_erro, m_apag, m_valid;
  logic [7:0] m_cont;

  function automatic vec_t lookup(input logic [6:0] p);
    vec_t r;
    r.pattern = p;
    r.hexa    = 5'h1E;
    r.erro    = 1'b1;
    r.apagado = 1'b0;
    for (int i = 0; i < 25; i++)
      if (vecs[i].pattern == p) r = vecs[i];
    return r;
  endfunction

  task automatic model_reset();
    m_s1 = 7'h7F; m_s2 = 7'h7F; m_last = 7'h7F; m_acc = 7'h7F;
    m_track = 1'b0; m_run = 0;
    m_hexa = 5'h1F; m_erro = 1'b0; m_apag = 1'b1; m_valid = 1'b0; m_cont = 8'd0;
  endtask

  task automatic model_edge();
    vec_t d;
    m_valid = 1'b0;
    if (m_track && bus.enable) begin
      if (m_run > 0 && m_s2 == m_last) m_run = (m_run < 1000) ? m_run + 1 : m_run;
      else m_run = 1;
      m_last = m_s2;
      if (m_run == N && m_s2 != m_acc) begin
        d       = lookup(m_s2);
        m_acc   = m_s2;
        m_hexa  = d.hexa;
        m_erro  = d.erro;
        m_apag  = d.apagado;
        m_valid = 1'b1;
        m_cont  = m_cont + 8'd1;
      end
    end else begin
      m_run = 0;
    end
    m_track = bus.enable;
    m_s2    = m_s1;
    m_s1    = bus.display;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check("hexa",     32'(bus.hexa),     32'(m_hexa));
    check("erro",     32'(bus.erro),     32'(m_erro));
    check("apagado",  32'(bus.apagado),  32'(m_apag));
    check("valid",    32'(bus.valid),    32'(m_valid));
    check("contagem", 32'(bus.contagem), 32'(m_cont));
  endtask

  task automatic applyStimulus(input logic [6:0] pattern, input int cycles);
    bus.display = pattern;
    for (int i = 0; i < cycles; i++) begin
      model_edge();
      @(posedge clock);
      #1;
      if (bus.valid) valid_seen++;
      checkOutput();
    end
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_hexa"},     32'(bus.hexa),     32'h1F);
    check({tag, "_apagado"},  32'(bus.apagado),  32'd1);
    check({tag, "_erro"},     32'(bus.erro),     32'd0);
    check({tag, "_valid"},    32'(bus.valid),    32'd0);
    check({tag, "_contagem"}, 32'(bus.contagem), 32'd0);
  endtask

  initial begin
    logic [7:0] c0;
    int         vs;

    vecs[0]  = '{7'h40, 5'h00, 1'b0, 1'b0};
    vecs[1]  = '{7'h79, 5'h01, 1'b0, 1'b0};
    vecs[2]  = '{7'h24, 5'h02, 1'b0, 1'b0};
    vecs[3]  = '{7'h30, 5'h03, 1'b0, 1'b0};
    vecs[4]  = '{7'h19, 5'h04, 1'b0, 1'b0};
    vecs[5]  = '{7'h12, 5'h05, 1'b0, 1'b0};
    vecs[6]  = '{7'h02, 5'h06, 1'b0, 1'b0};
    vecs[7]  = '{7'h78, 5'h07, 1'b0, 1'b0};
    vecs[8]  = '{7'h00, 5'h08, 1'b0, 1'b0};
    vecs[9]  = '{7'h10, 5'h09, 1'b0, 1'b0};
    vecs[10] = '{7'h08, 5'h0A, 1'b0, 1'b0};
    vecs[11] = '{7'h03, 5'h0B, 1'b0, 1'b0};
    vecs[12] = '{7'h46, 5'h0C, 1'b0, 1'b0};
    vecs[13] = '{7'h21, 5'h0D, 1'b0, 1'b0};
    vecs[14] = '{7'h06, 5'h0E, 1'b0, 1'b0};
    vecs[15] = '{7'h0E, 5'h0F, 1'b0, 1'b0};
    vecs[16] = '{7'h7E, 5'h10, 1'b0, 1'b0};
    vecs[17] = '{7'h7D, 5'h11, 1'b0, 1'b0};
    vecs[18] = '{7'h7B, 5'h12, 1'b0, 1'b0};
    vecs[19] = '{7'h77, 5'h13, 1'b0, 1'b0};
    vecs[20] = '{7'h6F, 5'h14, 1'b0, 1'b0};
    vecs[21] = '{7'h5F, 5'h15, 1'b0, 1'b0};
    vecs[22] = '{7'h7F, 5'h1F, 1'b0, 1'b1};
    vecs[23] = '{7'h55, 5'h1E, 1'b1, 1'b0};
    vecs[24] = '{7'h2A, 5'h1E, 1'b1, 1'b0};

    reset       = 1'b1;
    bus.enable  = 1'b0;
    bus.display = 7'h7F;
    model_reset();
    #3;
    checkResetValues("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Blank held with tracking on: nothing is ever accepted.
    bus.enable = 1'b1;
    valid_seen = 0;
    applyStimulus(7'h7F, 12);
    check("blank_no_valid", 32'(valid_seen), 32'd0);

    // Latency: acceptance registered on edge N+2 after the change.
    bus.display = 7'h24;
    for (int i = 1; i <= N + 2; i++) begin
      model_edge();
      @(posedge clock);
      #1;
      check($sformatf("lat_valid_e%0d", i), 32'(bus.valid), (i == N + 2) ? 32'd1 : 32'd0);
      checkOutput();
    end
    check("lat_hexa", 32'(bus.hexa), 32'h02);
    check("lat_cont", 32'(bus.contagem), 32'd1);
    applyStimulus(7'h24, 4);

    // Table sweep: one pulse per entry and the tabulated decode.
    foreach (vecs[k]) begin
      valid_seen = 0;
      applyStimulus(vecs[k].pattern, 10);
      check($sformatf("sweep%0d_pulses", k), 32'(valid_seen), 32'd1);
      check($sformatf("sweep%0d_hexa", k), 32'(bus.hexa), 32'(vecs[k].hexa));
      check($sformatf("sweep%0d_erro", k), 32'(bus.erro), 32'(vecs[k].erro));
      check($sformatf("sweep%0d_apag", k), 32'(bus.apagado), 32'(vecs[k].apagado));
    end

    // Short glitch that returns to the accepted pattern.
    applyStimulus(7'h40, 10);
    valid_seen = 0;
    applyStimulus(7'h79, 3);
    applyStimulus(7'h40, 10);
    check("glitch_no_valid", 32'(valid_seen), 32'd0);
    check("glitch_hexa", 32'(bus.hexa), 32'h00);

    // Two unknown patterns in a row, then 256 alternations wrap the counter.
    applyStimulus(7'h55, 10);
    c0 = bus.contagem;
    applyStimulus(7'h2A, 10);
    check("unk_second_cnt", 32'(bus.contagem), 32'(c0 + 8'd1));
    check("unk_second_erro", 32'(bus.erro), 32'd1);
    c0 = bus.contagem;
    valid_seen = 0;
    for (int i = 0; i < 256; i++) applyStimulus((i % 2 == 0) ? 7'h55 : 7'h2A, 6);
    check("wrap_pulses", 32'(valid_seen), 32'd256);
    check("wrap_cont", 32'(bus.contagem), 32'(c0));

    // Frozen while disabled, accepted N edges after re-enable.
    bus.enable = 1'b0;
    valid_seen = 0;
    applyStimulus(7'h0E, 9);
    check("disabled_no_valid", 32'(valid_seen), 32'd0);
    bus.enable = 1'b1;
    for (int i = 0; i <= N; i++) begin
      model_edge();
      @(posedge clock);
      #1;
      check($sformatf("reen_valid_%0d", i), 32'(bus.valid), (i == N) ? 32'd1 : 32'd0);
      checkOutput();
    end
    check("reen_hexa", 32'(bus.hexa), 32'h0F);

    // Reset two edges before the pending acceptance.
    valid_seen = 0;
    applyStimulus(7'h12, N);
    reset = 1'b1;
    #2;
    model_reset();
    checkResetValues("midreset");
    check("midreset_no_valid", 32'(valid_seen), 32'd0);
    #1;
    reset = 1'b0;
    applyStimulus(7'h12, 10);

    // Random patterns, hold lengths and enable.
    for (int i = 0; i < 80; i++) begin
      bus.enable = ($urandom_range(0, 9) != 0);
      vs = $urandom_range(0, 24);
      applyStimulus(($urandom_range(0, 3) == 0) ? 7'($urandom) : vecs[vs].pattern,
                    $urandom_range(1, 8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
